// File: rtl/mdu_seq_if.sv
// mdu_seq_if: start/flush request and HI/LO result bus of the multiply/divide unit
interface mdu_seq_if #(parameter int WIDTH = 32);
   logic start, flush, busy, done, z, dbz;
   logic [1:0] op;
   logic [WIDTH-1:0] in1, in2, hi, lo;
   modport master (output start, flush, op, in1, in2, input busy, done, hi, lo, z, dbz);
   modport slave (input start, flush, op, in1, in2, output busy, done, hi, lo, z, dbz);
endinterface

// File: rtl/mdu_seq.sv
// mdu_seq: iterative shift-add multiplier / restoring divider writing HI/LO
module mdu_seq #(parameter int WIDTH = 32) (
   input logic clk,
   input logic rst_n,
   mdu_seq_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
   state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic [1:0] op_q;
   logic sa, sb, dz, go, last, is_div, cap_sa, cap_sb, cap_dz;
   logic [WIDTH-1:0] mb, mag1, mag2, quo, rem, hi_nx, lo_nx;
   logic [2*WIDTH-1:0] acc, acc_nx, prod;
   logic [WIDTH:0] mul, rs, diff;
   assign go = state == IDLE && bus.start && !bus.flush;
   assign last = cnt == CW'(WIDTH - 1);
   assign is_div = op_q[0];
   assign cap_sa = bus.op[1] & bus.in1[WIDTH-1];
   assign cap_sb = bus.op[1] & bus.in2[WIDTH-1];
   assign cap_dz = bus.op[0] && bus.in2 == '0;
   assign mag1 = cap_sa ? -bus.in1 : bus.in1;
   assign mag2 = cap_sb ? -bus.in2 : bus.in2;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (go) state_nx = cap_dz ? FIN : RUN;
         RUN: if (bus.flush) state_nx = IDLE; else if (last) state_nx = FIN;
         default: state_nx = IDLE;
      endcase
   end
   // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
   always_comb begin
      mul = acc[0] ? {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mb} : {1'b0, acc[2*WIDTH-1:WIDTH]};
      rs = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      diff = rs - {1'b0, mb};
      acc_nx = !is_div ? {mul, acc[WIDTH-1:1]} :
               rs >= {1'b0, mb} ? {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1} :
               {rs[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      prod = (sa ^ sb) ? -acc : acc;
      quo = (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      hi_nx = dz ? '0 : is_div ? rem : prod[2*WIDTH-1:WIDTH];
      lo_nx = dz ? '0 : is_div ? quo : prod[WIDTH-1:0];
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         op_q <= '0;
         sa <= 1'b0;
         sb <= 1'b0;
         dz <= 1'b0;
         mb <= '0;
         acc <= '0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.hi <= '0;
         bus.lo <= '0;
         bus.z <= 1'b1;
         bus.dbz <= 1'b0;
      end else begin
         bus.done <= state == FIN;
         bus.busy <= state_nx == RUN || (state == RUN && state_nx == FIN);
         if (go) begin
            op_q <= bus.op;
            sa <= cap_sa;
            sb <= cap_sb;
            dz <= cap_dz;
            mb <= bus.op[0] ? mag2 : mag1;
            acc <= {{WIDTH{1'b0}}, bus.op[0] ? mag1 : mag2};
            cnt <= '0;
         end else if (state == RUN) begin
            acc <= acc_nx;
            if (!last) cnt <= cnt + CW'(1);
         end
         if (state == FIN) begin
            bus.hi <= hi_nx;
            bus.lo <= lo_nx;
            bus.z <= hi_nx == '0 && lo_nx == '0;
            bus.dbz <= dz;
         end
      end
   end
endmodule
